// File: rtl/perf_tcp_pkg.sv
// Shared register map, AXI response codes and per-channel config type
// for the multi-channel TCP perf client register file.
package perf_tcp_pkg;

    localparam int AXIL_ADDR_BITS = 64;

    localparam logic [2:0] REG_START     = 3'd0;
    localparam logic [2:0] REG_NUMSESS   = 3'd1;
    localparam logic [2:0] REG_WORDCOUNT = 3'd2;
    localparam logic [2:0] REG_SERVERIP  = 3'd3;
    localparam logic [2:0] REG_FREQ      = 3'd4;
    localparam logic [2:0] REG_TIME      = 3'd5;
    localparam logic [2:0] REG_TOTALWORD = 3'd6;
    localparam logic [2:0] REG_STATUS    = 3'd7;

    localparam logic [2:0] GREG_START_ALL = 3'd0;
    localparam logic [2:0] GREG_DONE      = 3'd1;
    localparam logic [2:0] GREG_ID        = 3'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic        start;
        logic [15:0] num_sessions;
        logic [31:0] pkg_word_count;
        logic [31:0] server_ip;
        logic [31:0] user_frequency;
        logic [31:0] time_in_seconds;
    } ch_cfg_t;

    // Byte-lane merge of a write into a 32-bit stored value.
    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/perf_tcp_ch_regs.sv
// One client channel: RW parameter bank, START auto-clear, saturating
// run-cycle counter and end-of-run (busy -> idle) edge detector.
module perf_tcp_ch_regs
    import perf_tcp_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        wr_en,
    input  logic [2:0]  wr_reg,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic        start_all,
    input  logic [3:0]  state_i,
    output ch_cfg_t     cfg_o,
    output logic [31:0] cycle_cnt_o,
    output logic        done_pulse_o
);

    ch_cfg_t     cfg_q, cfg_d;
    logic [31:0] cnt_q, cnt_d;
    logic        busy_prev_q, busy_prev_d;
    logic        running;
    logic        start_set;

    always_comb begin
        running   = (state_i != 4'd0);
        start_set = start_all | (wr_en && (wr_reg == REG_START) && wr_strb[0] && wr_data[0]);

        // Auto-clear first so a same-cycle write of START=1 overrides it.
        cfg_d = cfg_q;
        if (running) cfg_d.start = 1'b0;
        if (wr_en) begin
            case (wr_reg)
                REG_START:     if (wr_strb[0]) cfg_d.start = wr_data[0];
                REG_NUMSESS:   cfg_d.num_sessions = 16'(merge_strb({16'd0, cfg_q.num_sessions}, wr_data, wr_strb));
                REG_WORDCOUNT: cfg_d.pkg_word_count = merge_strb(cfg_q.pkg_word_count, wr_data, wr_strb);
                REG_SERVERIP:  cfg_d.server_ip = merge_strb(cfg_q.server_ip, wr_data, wr_strb);
                REG_FREQ:      cfg_d.user_frequency = merge_strb(cfg_q.user_frequency, wr_data, wr_strb);
                REG_TIME:      cfg_d.time_in_seconds = merge_strb(cfg_q.time_in_seconds, wr_data, wr_strb);
                default:       ;
            endcase
        end
        if (start_all) cfg_d.start = 1'b1;

        cnt_d = cnt_q;
        if (start_set) begin
            cnt_d = 32'd0;
        end else if (running && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end

        busy_prev_d = running;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cfg_q       <= '0;
            cnt_q       <= '0;
            busy_prev_q <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            busy_prev_q <= busy_prev_d;
        end
    end

    assign cfg_o        = cfg_q;
    assign cycle_cnt_o  = cnt_q;
    assign done_pulse_o = busy_prev_q && !running;

endmodule

// File: rtl/perf_tcp_ctrl_regfile_mc.sv
// AXI4-Lite control/status register file for N_CH TCP perf client engines,
// plus a global bank (start-all, sticky done mask, block ID).
module perf_tcp_ctrl_regfile_mc
    import perf_tcp_pkg::*;
#(
    parameter int          N_CH           = 4,
    parameter int          AXIL_DATA_BITS = 64,
    parameter logic [31:0] BLOCK_ID       = 32'h5443_5002
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXIL_ADDR_BITS-1:0]     axi_ctrl_awaddr,
    input  logic                          axi_ctrl_awvalid,
    output logic                          axi_ctrl_awready,
    input  logic [AXIL_DATA_BITS-1:0]     axi_ctrl_wdata,
    input  logic [AXIL_DATA_BITS/8-1:0]   axi_ctrl_wstrb,
    input  logic                          axi_ctrl_wvalid,
    output logic                          axi_ctrl_wready,
    output logic [1:0]                    axi_ctrl_bresp,
    output logic                          axi_ctrl_bvalid,
    input  logic                          axi_ctrl_bready,
    input  logic [AXIL_ADDR_BITS-1:0]     axi_ctrl_araddr,
    input  logic                          axi_ctrl_arvalid,
    output logic                          axi_ctrl_arready,
    output logic [AXIL_DATA_BITS-1:0]     axi_ctrl_rdata,
    output logic [1:0]                    axi_ctrl_rresp,
    output logic                          axi_ctrl_rvalid,
    input  logic                          axi_ctrl_rready,
    output logic [N_CH-1:0]               run_tx,
    output logic [N_CH-1:0][15:0]         num_sessions,
    output logic [N_CH-1:0][31:0]         pkg_word_count,
    output logic [N_CH-1:0][31:0]         server_ip,
    output logic [N_CH-1:0][31:0]         user_frequency,
    output logic [N_CH-1:0][31:0]         time_in_seconds,
    input  logic [N_CH-1:0][3:0]          state_i,
    input  logic [N_CH-1:0][31:0]         total_word_i
);

    localparam int CH_BITS = $clog2(N_CH + 1);

    logic                      awready_q, awready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [AXIL_DATA_BITS-1:0] rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [N_CH-1:0]           done_q, done_d;

    logic [2:0]                wr_reg, rd_reg;
    logic [CH_BITS-1:0]        wr_ch, rd_ch;
    logic                      wr_hs, rd_hs, wr_err, rd_err, glb_wr;
    logic [AXIL_DATA_BITS-1:0] rd_word;
    logic [N_CH-1:0]           ch_wr, start_all, start_one, done_clr, gmask, done_pulse;
    ch_cfg_t                   cfg [N_CH];
    logic [31:0]               cycle_cnt [N_CH];
    logic                      unused_ok;

    assign wr_reg = axi_ctrl_awaddr[3 +: 3];
    assign wr_ch  = axi_ctrl_awaddr[6 +: CH_BITS];
    assign rd_reg = axi_ctrl_araddr[3 +: 3];
    assign rd_ch  = axi_ctrl_araddr[6 +: CH_BITS];
    assign wr_hs  = awready_q && axi_ctrl_awvalid && axi_ctrl_wvalid;
    assign rd_hs  = arready_q && axi_ctrl_arvalid;

    // Write decode: errors block every state change of the access.
    always_comb begin
        wr_err = 1'b0;
        if (int'(wr_ch) > N_CH) begin
            wr_err = 1'b1;
        end else if (int'(wr_ch) == N_CH) begin
            wr_err = (wr_reg == GREG_ID);
        end else begin
            wr_err = (wr_reg == REG_TOTALWORD) || (wr_reg == REG_STATUS);
        end
        glb_wr = wr_hs && !wr_err && (int'(wr_ch) == N_CH);

        for (int c = 0; c < N_CH; c++) begin
            gmask[c]     = axi_ctrl_wdata[c] & axi_ctrl_wstrb[c/8];
            ch_wr[c]     = wr_hs && !wr_err && (int'(wr_ch) == c);
            start_all[c] = glb_wr && (wr_reg == GREG_START_ALL) && gmask[c];
            done_clr[c]  = glb_wr && (wr_reg == GREG_DONE) && gmask[c];
            start_one[c] = start_all[c] ||
                           (ch_wr[c] && (wr_reg == REG_START) && axi_ctrl_wstrb[0] && axi_ctrl_wdata[0]);
        end
        // A new end-of-run event wins over any clear in the same cycle.
        done_d = (done_q & ~done_clr & ~start_one) | done_pulse;
    end

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        if (int'(rd_ch) > N_CH) begin
            rd_err = 1'b1;
        end else if (int'(rd_ch) == N_CH) begin
            case (rd_reg)
                GREG_DONE: rd_word[N_CH-1:0] = done_q;
                GREG_ID:   rd_word[31:0]     = BLOCK_ID;
                default:   ;
            endcase
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (int'(rd_ch) == c) begin
                    case (rd_reg)
                        REG_START:     rd_word[0]     = cfg[c].start;
                        REG_NUMSESS:   rd_word[15:0]  = cfg[c].num_sessions;
                        REG_WORDCOUNT: rd_word[31:0]  = cfg[c].pkg_word_count;
                        REG_SERVERIP:  rd_word[31:0]  = cfg[c].server_ip;
                        REG_FREQ:      rd_word[31:0]  = cfg[c].user_frequency;
                        REG_TIME:      rd_word[31:0]  = cfg[c].time_in_seconds;
                        REG_TOTALWORD: rd_word[31:0]  = total_word_i[c];
                        default:       rd_word[63:0]  = {cycle_cnt[c], 28'd0, state_i[c]};
                    endcase
                end
            end
        end
    end

    always_comb begin
        awready_d = axi_ctrl_awvalid && axi_ctrl_wvalid && !bvalid_q && !awready_q;
        bvalid_d  = (bvalid_q && !axi_ctrl_bready) || wr_hs;
        bresp_d   = wr_hs ? (wr_err ? RESP_SLVERR : RESP_OKAY) : bresp_q;
        arready_d = axi_ctrl_arvalid && !arready_q && !rvalid_q;
        rvalid_d  = (rvalid_q && !axi_ctrl_rready) || rd_hs;
        rdata_d   = rd_hs ? rd_word : rdata_q;
        rresp_d   = rd_hs ? (rd_err ? RESP_SLVERR : RESP_OKAY) : rresp_q;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            done_q    <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            done_q    <= done_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        perf_tcp_ch_regs u_regs (
            .aclk         (aclk),
            .aresetn      (aresetn),
            .wr_en        (ch_wr[g]),
            .wr_reg       (wr_reg),
            .wr_data      (axi_ctrl_wdata[31:0]),
            .wr_strb      (axi_ctrl_wstrb[3:0]),
            .start_all    (start_all[g]),
            .state_i      (state_i[g]),
            .cfg_o        (cfg[g]),
            .cycle_cnt_o  (cycle_cnt[g]),
            .done_pulse_o (done_pulse[g])
        );
        assign run_tx[g]          = cfg[g].start;
        assign num_sessions[g]    = cfg[g].num_sessions;
        assign pkg_word_count[g]  = cfg[g].pkg_word_count;
        assign server_ip[g]       = cfg[g].server_ip;
        assign user_frequency[g]  = cfg[g].user_frequency;
        assign time_in_seconds[g] = cfg[g].time_in_seconds;
    end

    assign axi_ctrl_awready = awready_q;
    assign axi_ctrl_wready  = awready_q;
    assign axi_ctrl_bvalid  = bvalid_q;
    assign axi_ctrl_bresp   = bresp_q;
    assign axi_ctrl_arready = arready_q;
    assign axi_ctrl_rvalid  = rvalid_q;
    assign axi_ctrl_rdata   = rdata_q;
    assign axi_ctrl_rresp   = rresp_q;

    assign unused_ok = ^{axi_ctrl_awaddr[AXIL_ADDR_BITS-1:6+CH_BITS], axi_ctrl_awaddr[2:0],
                         axi_ctrl_araddr[AXIL_ADDR_BITS-1:6+CH_BITS], axi_ctrl_araddr[2:0],
                         axi_ctrl_wdata[AXIL_DATA_BITS-1:32], axi_ctrl_wstrb[AXIL_DATA_BITS/8-1:4]};

endmodule

// File: tb/tb_perf_tcp_ctrl_regfile_mc.sv
// Self-checking bench for perf_tcp_ctrl_regfile_mc: randomized register
// traffic against an array-based register model, plus directed scenarios.
module tb_perf_tcp_ctrl_regfile_mc;

    localparam int          N_CH = 4;
    localparam int          TMO  = 50;
    localparam logic [31:0] ID   = 32'h5443_5002;

    logic                   aclk = 1'b0;
    logic                   aresetn = 1'b0;
    logic [63:0]            awaddr = '0, araddr = '0, wdata = '0;
    logic [7:0]             wstrb = '0;
    logic                   awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic                   awready, wready, bvalid, arready, rvalid;
    logic [1:0]             bresp, rresp;
    logic [63:0]            rdata;
    logic [N_CH-1:0]        run_tx;
    logic [N_CH-1:0][15:0]  num_sessions;
    logic [N_CH-1:0][31:0]  pkg_word_count, server_ip, user_frequency, time_in_seconds;
    logic [N_CH-1:0][3:0]   state_i = '0;
    logic [N_CH-1:0][31:0]  total_word_i = '0;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: mdl[ch][reg] for the six RW registers, as the host sees them.
    logic [63:0] mdl [N_CH][6];

    always #5 aclk = ~aclk;

    perf_tcp_ctrl_regfile_mc #(.N_CH(N_CH), .AXIL_DATA_BITS(64), .BLOCK_ID(ID)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi_ctrl_awaddr(awaddr), .axi_ctrl_awvalid(awvalid), .axi_ctrl_awready(awready),
        .axi_ctrl_wdata(wdata), .axi_ctrl_wstrb(wstrb), .axi_ctrl_wvalid(wvalid), .axi_ctrl_wready(wready),
        .axi_ctrl_bresp(bresp), .axi_ctrl_bvalid(bvalid), .axi_ctrl_bready(bready),
        .axi_ctrl_araddr(araddr), .axi_ctrl_arvalid(arvalid), .axi_ctrl_arready(arready),
        .axi_ctrl_rdata(rdata), .axi_ctrl_rresp(rresp), .axi_ctrl_rvalid(rvalid), .axi_ctrl_rready(rready),
        .run_tx(run_tx), .num_sessions(num_sessions), .pkg_word_count(pkg_word_count),
        .server_ip(server_ip), .user_frequency(user_frequency), .time_in_seconds(time_in_seconds),
        .state_i(state_i), .total_word_i(total_word_i)
    );

    function automatic logic [63:0] addr_of(input int ch, input int r);
        return (64'(ch) << 6) | (64'(r) << 3);
    endfunction

    function automatic logic [63:0] width_mask(input int r);
        if (r == 0) return 64'h1;
        if (r == 1) return 64'hFFFF;
        return 64'hFFFF_FFFF;
    endfunction

    function automatic void mdl_write(input int ch, input int r, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++) begin
            if (s[b]) mdl[ch][r][8*b +: 8] = d[8*b +: 8];
        end
        mdl[ch][r] = mdl[ch][r] & width_mask(r);
    endfunction

    task automatic aw_w(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
        int n = 0;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        do begin @(posedge aclk); #1; n++; end while (!(awready && wready) && n < TMO);
        tests_run++;
        if (!(awready && wready)) begin
            tests_failed++;
            $display("FAIL aw_w_timeout addr=%h: awready/wready never seen in %0d cycles", addr, TMO);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic b_phase(output logic [1:0] resp);
        int n = 0;
        bready = 1'b1;
        while (!bvalid && n < TMO) begin @(posedge aclk); #1; n++; end
        resp = bresp;
        tests_run++;
        if (!bvalid) begin
            tests_failed++;
            resp = 2'b11;
            $display("FAIL b_timeout: bvalid never seen in %0d cycles", TMO);
        end
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             output logic [1:0] resp);
        aw_w(addr, data, strb);
        b_phase(resp);
    endtask

    task automatic axi_read(input logic [63:0] addr, output logic [63:0] data, output logic [1:0] resp);
        int n = 0;
        araddr = addr; arvalid = 1'b1;
        do begin @(posedge aclk); #1; n++; end while (!arready && n < TMO);
        if (!arready) begin
            tests_run++; tests_failed++;
            $display("FAIL ar_timeout addr=%h: arready never seen", addr);
            arvalid = 1'b0; data = '1; resp = 2'b11;
            return;
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < TMO) begin @(posedge aclk); #1; n++; end
        if (!rvalid) begin
            tests_run++; tests_failed++;
            $display("FAIL r_timeout addr=%h: rvalid never seen", addr);
            data = '1; resp = 2'b11;
            return;
        end
        data = rdata; resp = rresp; rready = 1'b1;
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] d; logic [1:0] rs;
        for (int c = 0; c < N_CH; c++) for (int r = 0; r < 6; r++) mdl[c][r] = '0;
        for (int c = 0; c < N_CH; c++) total_word_i[c] = $urandom;
        aresetn = 1'b0;
        repeat (4) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        tests_run++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_handshake got %b need 00000", {awready, wready, bvalid, arready, rvalid});
        end
        tests_run++;
        if (run_tx !== '0 || num_sessions !== '0 || pkg_word_count !== '0 || server_ip !== '0 ||
            user_frequency !== '0 || time_in_seconds !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs run_tx=%b server_ip=%h need all zero", run_tx, server_ip);
        end
        axi_read(addr_of(0, 1), d, rs);
        tests_run++;
        if (d !== 64'd0 || rs !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_read_numsess got %h/%b need 0/00", d, rs);
        end
        axi_read(addr_of(N_CH, 2), d, rs);
        tests_run++;
        if (d !== {32'd0, ID} || rs !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_id got %h/%b need %h/00", d, rs, ID);
        end
    endtask

    task automatic test_serverip();
        logic [63:0] d; logic [1:0] rs;
        axi_write(addr_of(2, 3), 64'h0A01_0102, 8'h0F, rs);
        mdl_write(2, 3, 64'h0A01_0102, 8'h0F);
        tests_run++;
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL serverip_bresp got %b need 00", rs); end
        tests_run++;
        if (server_ip[2] !== 32'h0A01_0102) begin
            tests_failed++; $display("FAIL serverip_port got %h need 0a010102", server_ip[2]);
        end
        tests_run++;
        if (server_ip[0] !== 32'd0 || server_ip[1] !== 32'd0 || server_ip[3] !== 32'd0) begin
            tests_failed++; $display("FAIL serverip_others got %h need only ch2 set", server_ip);
        end
        axi_read(addr_of(2, 3), d, rs);
        tests_run++;
        if (d !== 64'h0A01_0102 || rs !== 2'b00) begin
            tests_failed++; $display("FAIL serverip_readback got %h/%b need 0a010102/00", d, rs);
        end
    endtask

    task automatic test_random_rw();
        logic [63:0] d, data; logic [1:0] rs; logic [7:0] strb;
        int ch, r;
        for (int i = 0; i < 24; i++) begin
            ch = $urandom_range(0, N_CH - 1);
            r = $urandom_range(1, 5);
            data = {$urandom, $urandom};
            strb = 8'($urandom_range(1, 255));
            axi_write(addr_of(ch, r), data, strb, rs);
            mdl_write(ch, r, data, strb);
            tests_run++;
            if (rs !== 2'b00) begin tests_failed++; $display("FAIL rand_bresp ch%0d r%0d got %b need 00", ch, r, rs); end
            ch = $urandom_range(0, N_CH - 1);
            r = $urandom_range(0, 5);
            axi_read(addr_of(ch, r), d, rs);
            tests_run++;
            if (d !== mdl[ch][r] || rs !== 2'b00) begin
                tests_failed++; $display("FAIL rand_read ch%0d r%0d got %h/%b need %h/00", ch, r, d, rs, mdl[ch][r]);
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            tests_run++;
            if (num_sessions[c] !== mdl[c][1][15:0] || pkg_word_count[c] !== mdl[c][2][31:0] ||
                server_ip[c] !== mdl[c][3][31:0] || user_frequency[c] !== mdl[c][4][31:0] ||
                time_in_seconds[c] !== mdl[c][5][31:0] || run_tx[c] !== mdl[c][0][0]) begin
                tests_failed++;
                $display("FAIL rand_ports ch%0d got %h %h %h %h %h need %h %h %h %h %h", c,
                         num_sessions[c], pkg_word_count[c], server_ip[c], user_frequency[c], time_in_seconds[c],
                         mdl[c][1][15:0], mdl[c][2][31:0], mdl[c][3][31:0], mdl[c][4][31:0], mdl[c][5][31:0]);
            end
        end
    endtask

    task automatic test_errors();
        logic [63:0] d; logic [1:0] rs;
        axi_write(addr_of(1, 6), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rs);
        tests_run++;
        if (rs !== 2'b10) begin tests_failed++; $display("FAIL err_wr_totalword got %b need 10", rs); end
        axi_write(addr_of(6, 2), 64'h1234_5678, 8'hFF, rs);
        tests_run++;
        if (rs !== 2'b10) begin tests_failed++; $display("FAIL err_wr_ch6 got %b need 10", rs); end
        axi_write(addr_of(N_CH, 2), 64'h1, 8'hFF, rs);
        tests_run++;
        if (rs !== 2'b10) begin tests_failed++; $display("FAIL err_wr_id got %b need 10", rs); end
        axi_write(addr_of(N_CH, 4), 64'hF, 8'hFF, rs);
        tests_run++;
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL reserved_wr got %b need 00", rs); end
        axi_read(addr_of(1, 6), d, rs);
        tests_run++;
        if (d !== {32'd0, total_word_i[1]} || rs !== 2'b00) begin
            tests_failed++; $display("FAIL totalword_read got %h/%b need %h/00", d, rs, total_word_i[1]);
        end
        axi_read(addr_of(6, 3), d, rs);
        tests_run++;
        if (d !== 64'd0 || rs !== 2'b10) begin tests_failed++; $display("FAIL err_rd_ch6 got %h/%b need 0/10", d, rs); end
        axi_read(addr_of(N_CH, 4), d, rs);
        tests_run++;
        if (d !== 64'd0 || rs !== 2'b00) begin tests_failed++; $display("FAIL reserved_rd got %h/%b need 0/00", d, rs); end
        axi_read(addr_of(N_CH, 2), d, rs);
        tests_run++;
        if (d !== {32'd0, ID}) begin tests_failed++; $display("FAIL id_after_write got %h need %h", d, ID); end
        for (int c = 0; c < N_CH; c++) begin
            tests_run++;
            if (pkg_word_count[c] !== mdl[c][2][31:0] || run_tx[c] !== 1'b0 || server_ip[c] !== mdl[c][3][31:0]) begin
                tests_failed++;
                $display("FAIL err_nochange ch%0d got wc=%h ip=%h run=%b need wc=%h ip=%h run=0", c,
                         pkg_word_count[c], server_ip[c], run_tx[c], mdl[c][2][31:0], mdl[c][3][31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; logic [1:0] rs, rr;
        bit held;
        aw_w(addr_of(0, 4), 64'h1111_2222, 8'h0F);
        mdl_write(0, 4, 64'h1111_2222, 8'h0F);
        awaddr = addr_of(0, 4); wdata = 64'h3333_4444; wstrb = 8'h0F; awvalid = 1'b1; wvalid = 1'b1;
        held = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    if (!bvalid || bresp !== 2'b00 || awready || wready) held = 1'b0;
                    @(posedge aclk); #1;
                end
            end
            axi_read(addr_of(0, 4), d, rr);
        join
        tests_run++;
        if (!held) begin tests_failed++; $display("FAIL bready_hold bvalid/awready got unstable need bvalid=1 awready=0"); end
        tests_run++;
        if (d !== mdl[0][4] || rr !== 2'b00) begin
            tests_failed++; $display("FAIL concurrent_read got %h/%b need %h/00", d, rr, mdl[0][4]);
        end
        b_phase(rs);
        aw_w(addr_of(0, 4), 64'h3333_4444, 8'h0F);
        b_phase(rs);
        mdl_write(0, 4, 64'h3333_4444, 8'h0F);
        tests_run++;
        if (user_frequency[0] !== mdl[0][4][31:0] || rs !== 2'b00) begin
            tests_failed++; $display("FAIL second_write got %h/%b need %h/00", user_frequency[0], rs, mdl[0][4][31:0]);
        end
    endtask

    task automatic test_start_all_done();
        logic [63:0] d; logic [1:0] rs;
        int ncyc;
        ncyc = $urandom_range(3, 20);
        axi_write(addr_of(N_CH, 0), 64'h5, 8'h01, rs);
        tests_run++;
        if (run_tx !== 4'b0101 || rs !== 2'b00) begin
            tests_failed++; $display("FAIL start_all got %b/%b need 0101/00", run_tx, rs);
        end
        state_i[0] = 4'd1;
        repeat (ncyc) @(posedge aclk);
        #1 state_i[0] = 4'd0;
        tests_run++;
        if (run_tx !== 4'b0100) begin tests_failed++; $display("FAIL start_autoclear got %b need 0100", run_tx); end
        @(posedge aclk); #1;
        axi_read(addr_of(0, 7), d, rs);
        tests_run++;
        if (d !== {32'(ncyc), 32'd0}) begin
            tests_failed++; $display("FAIL status_cycles got %h need %h", d, {32'(ncyc), 32'd0});
        end
        axi_read(addr_of(N_CH, 1), d, rs);
        tests_run++;
        if (d !== 64'h1) begin tests_failed++; $display("FAIL done_set got %h need 1", d); end
        axi_write(addr_of(N_CH, 1), 64'h1, 8'h01, rs);
        axi_read(addr_of(N_CH, 1), d, rs);
        tests_run++;
        if (d !== 64'h0) begin tests_failed++; $display("FAIL done_w1c got %h need 0", d); end
    endtask

    task automatic test_start_race();
        logic [1:0] rs;
        state_i[3] = 4'd2;
        @(posedge aclk); #1;
        aw_w(addr_of(3, 0), 64'h1, 8'h01);
        tests_run++;
        if (run_tx[3] !== 1'b1) begin tests_failed++; $display("FAIL start_wins got %b need 1", run_tx[3]); end
        @(posedge aclk); #1;
        tests_run++;
        if (run_tx[3] !== 1'b0) begin tests_failed++; $display("FAIL start_clears_next got %b need 0", run_tx[3]); end
        b_phase(rs);
        state_i[3] = 4'd0;
        tests_run++;
        if (rs !== 2'b00) begin tests_failed++; $display("FAIL start_race_bresp got %b need 00", rs); end
    endtask

    initial begin
        test_reset();
        test_serverip();
        test_random_rw();
        test_errors();
        test_back_to_back();
        test_start_all_done();
        test_start_race();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/perf_tcp_ctrl_regfile_mc.md
Name: perf_tcp_ctrl_regfile_mc

Overview:
- Multi-channel AXI4-Lite control/status register file for the TCP perf client vFPGA.
- Drives N_CH independent client engines, each with its own parameter bank, start trigger, status and run-cycle counter.
- Adds a global bank with start-all, sticky done and ID registers.
- Adds read-back of RW registers and SLVERR on illegal accesses.
- Sits between axi_ctrl (host via PCIe/XDMA) and the per-channel TCP traffic generators.

Parameters:
- N_CH, 4, number of client channels (1..8).
- AXIL_DATA_BITS, 64 (from lynxTypes), AXI-Lite data width; must be 64.
- BLOCK_ID, 32'h5443_5002, constant returned by global ID register.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- axi_ctrl  AXI4L.s  -  host control slave
- run_tx  out  N_CH  per-channel start level
- num_sessions  out  N_CH x 16  connections per channel
- pkg_word_count  out  N_CH x 32  64-byte words per TCP payload
- server_ip  out  N_CH x 32  server IPv4 address
- user_frequency  out  N_CH x 32  pacing value
- time_in_seconds  out  N_CH x 32  run duration
- state_i  in  N_CH x 4  engine state; 0 = idle
- total_word_i  in  N_CH x 32  words sent by engine

Behaviour:
- Reset is aresetn, synchronous, active-low; clock is aclk. All outputs, registers, counters and AXI handshake signals reset to 0.
- Address decode: reg = addr[3+:3], ch = addr[6+:CH_BITS], CH_BITS = $clog2(N_CH+1). ch == N_CH selects the global bank; ch > N_CH is unmapped.
- Per-channel map:
  - 0 START RW, bit0
  - 1 NUMSESS RW [15:0]
  - 2 WORDCOUNT RW
  - 3 SERVERIP RW
  - 4 FREQ RW
  - 5 TIME RW
  - 6 TOTALWORD RO
  - 7 STATUS RO: [3:0] state_i, [63:32] cycle counter
- Global map:
  - 0 START_ALL, write-1-to-set into every START[ch]
  - 1 DONE RO/W1C sticky mask [N_CH-1:0]
  - 2 ID RO = BLOCK_ID
  - 3..7 reserved: read 0 OKAY, write ignored OKAY
- Write handshake:
  - awready and wready assert together for one cycle when awvalid & wvalid & ~bvalid & ~(awready|wready).
  - Register update occurs in that same cycle using wstrb byte enables; outputs change one cycle later.
  - bvalid asserts the next cycle and holds until bready.
  - bresp = 2'b00, or 2'b10 (SLVERR) for a write to RO registers 6/7, global ID, or ch > N_CH. An erroring write changes no state.
- Read handshake:
  - arready pulses one cycle when arvalid & ~arready & ~rvalid.
  - rdata is captured the same edge; rvalid asserts the next cycle and holds until rready.
  - Reads of RW registers return stored values; unused bits read 0.
  - ch > N_CH returns rdata 0 with rresp 2'b10.
  - Read and write paths are independent; simultaneous accesses are both serviced.
- START[ch]:
  - Cleared every cycle state_i[ch] != 0.
  - A write setting START in the same cycle wins over the auto-clear.
  - run_tx[ch] = START[ch] bit0.
- Cycle counter[ch]:
  - Cleared in the cycle START[ch] is written 1, directly or via START_ALL.
  - Otherwise increments each cycle state_i[ch] != 0.
  - Saturates at 32'hFFFF_FFFF.
- DONE[ch]:
  - Set when state_i[ch] goes from nonzero to 0; edge detected against a registered copy.
  - Cleared by W1C. A set in the same cycle wins over the clear.
  - Writing START[ch]=1 also clears DONE[ch].
- Status inputs are sampled at read-capture time; no CDC, all in aclk.
- Reset asserted mid-transaction drops any pending bvalid/rvalid; the host must re-issue.

Decomposition:
- perf_tcp_pkg:
  - register index constants: REG_START, REG_NUMSESS, REG_WORDCOUNT, REG_SERVERIP, REG_FREQ, REG_TIME, REG_TOTALWORD, REG_STATUS, GREG_START_ALL, GREG_DONE, GREG_ID
  - AXI resp constants RESP_OKAY, RESP_SLVERR
  - typedef ch_cfg_t: struct of the six RW fields
- Sub-module perf_tcp_ch_regs, instantiated N_CH times via generate. It holds one channel's RW bank, START auto-clear, cycle counter and done-edge detector; inputs are a decoded write strobe/data/wstrb and start_all.
- The top module keeps AXI handshakes, decode and read mux.

Test Plan:
- Reset, then read ch0 reg1 and global ID → rdata 0, then 32'h5443_5002; both rresp OKAY.
- Write ch2 SERVERIP = 0x0A01_0102 with wstrb 0x0F, read back → server_ip[2] = 0x0A010102 one cycle after the write; readback matches; other channels unchanged.
- Write START_ALL = 0b0101 (N_CH=4) → run_tx = 0101. Drive state_i[0] = 1 for 10 cycles then 0 → START[0] clears, STATUS[0][63:32] = 10, DONE bit0 = 1. W1C 0b0001 → DONE = 0.
- Write ch1 TOTALWORD, and address ch = 6 → bresp SLVERR; no register changes. Read ch = 6 → rdata 0, rresp SLVERR.
- Hold bready low 5 cycles after a write, with a concurrent read → bvalid held stable, no second write accepted, read completes normally.
- Write START[3] = 1 in the same cycle state_i[3] != 0 → run_tx[3] = 1 next cycle; clears on the following cycle.
